// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit add/correct stage
// walks the operand digits LSB first, one digit per clock, with a
// start/busy/done handshake. Results are registered and held until the
// next completed operation.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 3,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               err_pend_q, err_pend_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;

    logic [3:0]         dig_a, dig_b, dig_out;
    logic [4:0]         raw;
    logic               carry_nx;
    logic [W-1:0]       res_upd;
    logic               bad_in;
    logic               last_digit;

    // Single-digit BCD add/correct on the digit selected by idx, merged into the partial result
    always_comb begin
        dig_a   = '0;
        dig_b   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == CNT_W'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
        raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        if (raw > 5'd9) begin
            dig_out  = raw[3:0] + 4'd6;
            carry_nx = 1'b1;
        end else begin
            dig_out  = raw[3:0];
            carry_nx = 1'b0;
        end
        res_upd = res_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == CNT_W'(i)) begin
                res_upd[4*i +: 4] = dig_out;
            end
        end
        last_digit = (idx_q == CNT_W'(DIGITS - 1));
    end

    // Flag any non-BCD digit on the request inputs
    always_comb begin
        bad_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad_in = 1'b1;
            end
        end
    end

    // Next-state and datapath register update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        err_pend_d = err_pend_q;
        cout_d     = cout_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    err_pend_d = bad_in;
                    idx_d      = '0;
                    res_d      = '0;
                    state_d    = RUN;
                end else begin
                    state_d    = IDLE;
                end
            end
            RUN: begin
                res_d   = res_upd;
                carry_d = carry_nx;
                idx_d   = idx_q + CNT_W'(1);
                if (last_digit) begin
                    sum_d   = res_upd;
                    cout_d  = carry_nx;
                    err_d   = err_pend_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            err_pend_q <= 1'b0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            err_pend_q <= err_pend_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for the digit-serial BCD adder sequencer.
module tb_bcd_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] a_in = '0;
    logic [11:0] b_in = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, err;
    logic [11:0] sum;

    typedef struct {
        logic [11:0] sum;
        logic        cout;
        logic        err;
        int          cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   rd = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bcd_serial_adder_ctrl #(.DIGITS(3), .CNT_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a_in),
        .b    (b_in),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Capture every completed result just after the edge that raised done
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (done === 1'b1) begin
            res_t r;
            r.sum = sum; r.cout = cout; r.err = err; r.cyc = cyc;
            obs_q.push_back(r);
        end
    end

    function automatic int dec3(input logic [11:0] x);
        return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic res_t model(input logic [11:0] x, input logic [11:0] y, input logic c);
        res_t r;
        int t;
        t = dec3(x) + dec3(y) + int'(c);
        r.cout = (t >= 1000);
        t = t % 1000;
        r.sum = {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
        r.err = 1'b0;
        r.cyc = 0;
        return r;
    endfunction

    function automatic res_t mk(input logic [11:0] s, input logic c, input logic e);
        res_t r;
        r.sum = s; r.cout = c; r.err = e; r.cyc = 0;
        return r;
    endfunction

    task automatic run_op(input logic [11:0] x, input logic [11:0] y, input logic c);
        @(negedge clk);
        a_in = x; b_in = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({sum, cout, err} !== 14'h0) begin errors++; $display("FAIL reset_outputs: got sum=%h cout=%b err=%b want 000/0/0", sum, cout, err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        res_t e, o;
        @(negedge clk);
        a_in = 12'h349; b_in = 12'h651; cin = 1'b0; start = 1'b1;
        exp_q.push_back(mk(12'h000, 1'b1, 1'b0));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy_c%0d: got busy=%b done=%b want 1/0", k, busy, done); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_latency: got done=%b busy=%b want 1/0", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b want 0", done); end
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_values;
        res_t e, o;
        logic [11:0] x, y;
        logic c;
        run_op(12'h015, 12'h027, 1'b0); exp_q.push_back(mk(12'h042, 1'b0, 1'b0));
        run_op(12'h999, 12'h000, 1'b1); exp_q.push_back(mk(12'h000, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            x = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            y = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            c = 1'($urandom_range(1));
            run_op(x, y, c); exp_q.push_back(model(x, y, c));
        end
        run_op(12'h999, 12'h999, 1'b1); exp_q.push_back(mk(12'h999, 1'b1, 1'b0));
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL values_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL values_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_ignore_start;
        res_t e, o;
        @(negedge clk);
        a_in = 12'h099; b_in = 12'h001; cin = 1'b0; start = 1'b1;
        exp_q.push_back(mk(12'h100, 1'b0, 1'b0));
        @(negedge clk);
        a_in = 12'h500; b_in = 12'h500;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (sum !== 12'h999 || busy !== 1'b1) begin errors++; $display("FAIL ignore_hold_c%0d: got sum=%h busy=%b want 999/1", k, sum, busy); end
            if (k == 2) start = 1'b0;
            if (k < 3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL ignore_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL ignore_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_back_to_back;
        res_t e, o;
        int prev_cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1;
            if (i % 2 == 0) begin
                a_in = 12'h009; b_in = 12'h001; exp_q.push_back(mk(12'h010, 1'b0, 1'b0));
            end else begin
                a_in = 12'h500; b_in = 12'h500; exp_q.push_back(mk(12'h000, 1'b1, 1'b0));
            end
            cin = 1'b0;
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        prev_cyc = -1;
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL b2b_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
            if (prev_cyc >= 0) begin
                checks++; if (o.cyc - prev_cyc != 4) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want 4", o.cyc - prev_cyc); end
            end
            prev_cyc = o.cyc;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_reset_mid_run;
        res_t e, o;
        @(negedge clk);
        a_in = 12'h123; b_in = 12'h456; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (sum !== 12'h000 || cout !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got %h/%b/%b want 000/0/0", sum, cout, err); end
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != rd) begin errors++; $display("FAIL midrst_no_done: got %0d results want 0", obs_q.size() - rd); end
        rd = obs_q.size();
        run_op(12'h123, 12'h456, 1'b0); exp_q.push_back(mk(12'h579, 1'b0, 1'b0));
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL midrst_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_err;
        res_t e, o;
        // 0xA at digit 0 corrects to 0 with carry, giving 0x010
        run_op(12'h00A, 12'h000, 1'b0); exp_q.push_back(mk(12'h010, 1'b0, 1'b1));
        run_op(12'h001, 12'h002, 1'b0); exp_q.push_back(mk(12'h003, 1'b0, 1'b0));
        checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL err_count: got %0d results want %0d", obs_q.size() - rd, exp_q.size()); end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[rd]; rd++;
            checks++; if ({o.sum, o.cout, o.err} !== {e.sum, e.cout, e.err}) begin errors++; $display("FAIL err_result: got %h/%b/%b want %h/%b/%b", o.sum, o.cout, o.err, e.sum, e.cout, e.err); end
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        test_err;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
